window_buffer_kxk: RTL and testbench

Parametrised K×K sliding-window buffer for the image-filter pipeline. It sits between the K-row line buffer and the K×K kernel datapaths (median, Gaussian, morphology). Each accepted beat carries one K-pixel column and is shifted into a K×K register window. A row/column sequencer marks which windows are valid and signals end of frame. This block replaces the fixed 3×3/5×5/7×7 window buffers and adds a valid/ready handshake and optional zero-padded borders.

---
 rtl/window_buffer_pkg.sv | 14 +
 rtl/window_buffer_kxk_if.sv | 24 ++
 rtl/window_buffer_kxk_seq.sv | 138 +++++++++++++
 rtl/window_buffer_kxk.sv | 63 ++++++
 tb/tb_window_buffer_kxk.sv | 275 +++++++++++++++++++++++++++
 5 files changed

// File: rtl/window_buffer_pkg.sv
// Shared definitions for the K x K sliding-window buffer: FSM encoding and
// the half-kernel helper used for border handling.
package window_buffer_pkg;

  localparam logic [1:0] ST_IDLE  = 2'd0;
  localparam logic [1:0] ST_RUN   = 2'd1;
  localparam logic [1:0] ST_FLUSH = 2'd2;
  localparam logic [1:0] ST_DONE  = 2'd3;

  function automatic int win_h(input int k);
    return (k - 1) / 2;
  endfunction

endpackage

// File: rtl/window_buffer_kxk_if.sv
// Column-in / window-out handshake bundle for window_buffer_kxk.
interface window_buffer_kxk_if #(
  parameter int K      = 7,
  parameter int DATA_W = 8
);
  logic                    start_i;
  logic                    valid_i;
  logic                    ready_o;
  logic [K*DATA_W-1:0]     col_i;
  logic [K*K*DATA_W-1:0]   window_o;
  logic                    valid_o;
  logic                    busy_o;
  logic                    done_o;

  modport master (
    output start_i, valid_i, col_i,
    input  ready_o, window_o, valid_o, busy_o, done_o
  );

  modport slave (
    input  start_i, valid_i, col_i,
    output ready_o, window_o, valid_o, busy_o, done_o
  );
endinterface

// File: rtl/window_buffer_kxk_seq.sv
// Row/column sequencer for window_buffer_kxk: FSM, counters, window-valid and
// end-of-frame flags. Zero-padded borders when WINDOW_BUFFER_ZERO_PAD_EN is defined.
module window_buffer_kxk_seq
  import window_buffer_pkg::*;
#(
  parameter int K    = 7,
  parameter int COLS = 640,
  parameter int ROWS = 480
) (
  input  logic clk,
  input  logic rst,
  input  logic start_i,
  input  logic valid_i,
  output logic ready_o,
  output logic busy_o,
  output logic shift_en,
  output logic zero_col,
  output logic clr_win,
  output logic valid_o,
  output logic done_o
);

  localparam int H  = win_h(K);
  localparam int CW = $clog2(COLS);
  localparam int RW = (ROWS > 1) ? $clog2(ROWS) : 1;
  localparam int FW = $clog2(H + 1);

  logic [1:0]    state, state_nxt;
  logic [CW-1:0] col_cnt, col_nxt;
  logic [RW-1:0] row_cnt, row_nxt;
  logic [FW-1:0] fl_cnt, fl_nxt;
  logic          accept, win_vld, last_win;
  logic          ready_p1, vld_p1, done_p1;

  assign accept = valid_i && ready_p1;

  always_comb begin
    state_nxt = state;
    col_nxt   = col_cnt;
    row_nxt   = row_cnt;
    fl_nxt    = fl_cnt;
    shift_en  = 1'b0;
    zero_col  = 1'b0;
    clr_win   = 1'b0;
    win_vld   = 1'b0;
    last_win  = 1'b0;
    case (state)
      ST_IDLE: begin
        if (start_i) begin
          state_nxt = ST_RUN;
          col_nxt   = '0;
          row_nxt   = '0;
          fl_nxt    = '0;
          clr_win   = 1'b1;
        end
      end
      ST_RUN: begin
        // Nothing of the current row is in the window yet at column 0, so
        // the shift (or idle cycle) starts from an empty window.
        clr_win = (col_cnt == '0);
        if (accept) begin
          shift_en = 1'b1;
`ifdef WINDOW_BUFFER_ZERO_PAD_EN
          win_vld = (col_cnt >= CW'(H));
          if (col_cnt == CW'(COLS - 1)) begin
            state_nxt = ST_FLUSH;
            fl_nxt    = '0;
          end else begin
            col_nxt = col_cnt + 1'b1;
          end
`else
          win_vld = (col_cnt >= CW'(K - 1));
          if (col_cnt == CW'(COLS - 1)) begin
            col_nxt = '0;
            if (row_cnt == RW'(ROWS - 1)) begin
              state_nxt = ST_DONE;
              last_win  = 1'b1;
            end else begin
              row_nxt = row_cnt + 1'b1;
            end
          end else begin
            col_nxt = col_cnt + 1'b1;
          end
`endif
        end
      end
`ifdef WINDOW_BUFFER_ZERO_PAD_EN
      ST_FLUSH: begin
        shift_en = 1'b1;
        zero_col = 1'b1;
        win_vld  = 1'b1;
        if (fl_cnt == FW'(H - 1)) begin
          fl_nxt  = '0;
          col_nxt = '0;
          if (row_cnt == RW'(ROWS - 1)) begin
            state_nxt = ST_DONE;
            last_win  = 1'b1;
          end else begin
            row_nxt   = row_cnt + 1'b1;
            state_nxt = ST_RUN;
          end
        end else begin
          fl_nxt = fl_cnt + 1'b1;
        end
      end
`endif
      ST_DONE: state_nxt = ST_IDLE;
      default: state_nxt = ST_IDLE;
    endcase
  end

  // Stage p1: state, counters and output flags registered together
  always_ff @(posedge clk) begin
    if (rst) begin
      state    <= ST_IDLE;
      col_cnt  <= '0;
      row_cnt  <= '0;
      fl_cnt   <= '0;
      ready_p1 <= 1'b0;
      vld_p1   <= 1'b0;
      done_p1  <= 1'b0;
    end else begin
      state    <= state_nxt;
      col_cnt  <= col_nxt;
      row_cnt  <= row_nxt;
      fl_cnt   <= fl_nxt;
      ready_p1 <= (state_nxt == ST_RUN);
      vld_p1   <= win_vld;
      done_p1  <= last_win;
    end
  end

  assign ready_o = ready_p1;
  assign busy_o  = (state != ST_IDLE);
  assign valid_o = vld_p1;
  assign done_o  = done_p1;

endmodule

// File: rtl/window_buffer_kxk.sv
// K x K sliding-window buffer: shifts one K-pixel column per accepted beat into
// a K x K register window. Zero-padded borders when WINDOW_BUFFER_ZERO_PAD_EN is defined.
module window_buffer_kxk
  import window_buffer_pkg::*;
#(
  parameter int K      = 7,
  parameter int DATA_W = 8,
  parameter int COLS   = 640,
  parameter int ROWS   = 480
) (
  input logic                clk,
  input logic                rst,
  window_buffer_kxk_if.slave bus
);

  logic [K*K*DATA_W-1:0] win_p1, win_base, win_shift;
  logic                  shift_en, zero_col, clr_win;

  window_buffer_kxk_seq #(
    .K    (K),
    .COLS (COLS),
    .ROWS (ROWS)
  ) u_seq (
    .clk      (clk),
    .rst      (rst),
    .start_i  (bus.start_i),
    .valid_i  (bus.valid_i),
    .ready_o  (bus.ready_o),
    .busy_o   (bus.busy_o),
    .shift_en (shift_en),
    .zero_col (zero_col),
    .clr_win  (clr_win),
    .valid_o  (bus.valid_o),
    .done_o   (bus.done_o)
  );

  // Column c takes c+1; the newest column (or a zero border column) enters at K-1
  always_comb begin
    win_base  = clr_win ? '0 : win_p1;
    win_shift = '0;
    for (int r = 0; r < K; r++) begin
      for (int c = 0; c < K; c++) begin
        if (c < K - 1)
          win_shift[(r*K+c)*DATA_W +: DATA_W] = win_base[(r*K+c+1)*DATA_W +: DATA_W];
        else
          win_shift[(r*K+c)*DATA_W +: DATA_W] = zero_col ? '0 : bus.col_i[r*DATA_W +: DATA_W];
      end
    end
  end

  // Stage p1: window register
  always_ff @(posedge clk) begin
    if (rst)
      win_p1 <= '0;
    else if (shift_en)
      win_p1 <= win_shift;
    else if (clr_win)
      win_p1 <= '0;
  end

  assign bus.window_o = win_p1;

endmodule

// File: tb/tb_window_buffer_kxk.sv
// Scoreboard bench for window_buffer_kxk: a K=3 instance and a K=7 instance,
// expected windows derived from image coordinates.
module tb_window_buffer_kxk;

  localparam int KA = 3, CA = 5,  RA = 2;
  localparam int KB = 7, CB = 10, RB = 1;
  localparam int WA = KA*KA*8;
  localparam int WB = KB*KB*8;
`ifdef WINDOW_BUFFER_ZERO_PAD_EN
  localparam bit PAD = 1'b1;
`else
  localparam bit PAD = 1'b0;
`endif

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  window_buffer_kxk_if #(.K(KA), .DATA_W(8)) ifa ();
  window_buffer_kxk_if #(.K(KB), .DATA_W(8)) ifb ();

  window_buffer_kxk #(.K(KA), .DATA_W(8), .COLS(CA), .ROWS(RA)) dut_a (
    .clk (clk), .rst (rst), .bus (ifa)
  );
  window_buffer_kxk #(.K(KB), .DATA_W(8), .COLS(CB), .ROWS(RB)) dut_b (
    .clk (clk), .rst (rst), .bus (ifb)
  );

  int checks = 0;
  int errors = 0;
  int done_a = 0;
  int done_b = 0;
  logic [WB-1:0] qa_w[$];
  logic [WB-1:0] qb_w[$];
  bit            qa_d[$];
  bit            qb_d[$];

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h required=%0h", nm, act, exp);
    end
  endtask

  function automatic logic [7:0] pix(input int mode, input int band, input int r, input int x);
    if (mode == 0) return 8'(band*128 + r*16 + x);
    return (band == 0) ? 8'hFF : 8'h00;
  endfunction

  // Window at output position x covers image columns x-(k-1) .. x; off-image is zero
  function automatic logic [WB-1:0] exp_win(input int k, input int cols, input int mode,
                                            input int band, input int x);
    logic [WB-1:0] w;
    int j;
    w = '0;
    for (int r = 0; r < k; r++)
      for (int c = 0; c < k; c++) begin
        j = x - (k - 1) + c;
        if (j >= 0 && j < cols) w[(r*k+c)*8 +: 8] = pix(mode, band, r, j);
      end
    return w;
  endfunction

  function automatic logic [KB*8-1:0] mk_col(input int k, input int mode, input int band, input int x);
    logic [KB*8-1:0] col;
    col = '0;
    for (int r = 0; r < k; r++) col[r*8 +: 8] = pix(mode, band, r, x);
    return col;
  endfunction

  function automatic logic rd_ready(input int inst);
    return (inst == 0) ? ifa.ready_o : ifb.ready_o;
  endfunction
  function automatic logic rd_valid(input int inst);
    return (inst == 0) ? ifa.valid_o : ifb.valid_o;
  endfunction
  function automatic logic rd_busy(input int inst);
    return (inst == 0) ? ifa.busy_o : ifb.busy_o;
  endfunction
  function automatic logic rd_done(input int inst);
    return (inst == 0) ? ifa.done_o : ifb.done_o;
  endfunction
  function automatic logic rd_win_nz(input int inst);
    return (inst == 0) ? (|ifa.window_o) : (|ifb.window_o);
  endfunction

  task automatic set_in(input int inst, input logic v, input logic [KB*8-1:0] col);
    if (inst == 0) begin
      ifa.valid_i = v;
      ifa.col_i   = col[KA*8-1:0];
    end else begin
      ifb.valid_i = v;
      ifb.col_i   = col;
    end
  endtask

  task automatic set_start(input int inst, input logic v);
    if (inst == 0) ifa.start_i = v;
    else           ifb.start_i = v;
  endtask

  task automatic chk_idle_outputs(input int inst, input string tag);
    chk({tag, "_ready"}, rd_ready(inst), 0);
    chk({tag, "_valid"}, rd_valid(inst), 0);
    chk({tag, "_busy"},  rd_busy(inst),  0);
    chk({tag, "_done"},  rd_done(inst),  0);
    chk({tag, "_win"},   rd_win_nz(inst), 0);
  endtask

  task automatic run_frame(input int inst, input int mode, input bit gap,
                           input int abort_after, input bit start_mid);
    int k, cols, rows, h, x0, x1, n, lo, t;
    logic [WB-1:0] w;
    k    = (inst == 0) ? KA : KB;
    cols = (inst == 0) ? CA : CB;
    rows = (inst == 0) ? RA : RB;
    h    = (k - 1) / 2;
    x0   = PAD ? h : k - 1;
    x1   = PAD ? cols + h - 1 : cols - 1;
    for (int b = 0; b < rows; b++)
      for (int x = x0; x <= x1; x++) begin
        w = exp_win(k, cols, mode, b, x);
        if (inst == 0) begin
          qa_w.push_back(w);
          qa_d.push_back(b == rows - 1 && x == x1);
        end else begin
          qb_w.push_back(w);
          qb_d.push_back(b == rows - 1 && x == x1);
        end
      end
    done_a = 0;
    done_b = 0;
    set_start(inst, 1'b1);
    @(posedge clk); #1;
    set_start(inst, 1'b0);
    chk("ready_after_start", rd_ready(inst), 1);
    chk("win_clr_on_start", rd_win_nz(inst), 0);
    n = 0;
    for (int b = 0; b < rows; b++)
      for (int x = 0; x < cols; x++) begin
        if (abort_after > 0 && n == abort_after) begin
          set_in(inst, 1'b0, '0);
          rst = 1'b1;
          @(posedge clk); #1;
          rst = 1'b0;
          chk_idle_outputs(inst, "abort");
          qa_w.delete(); qa_d.delete();
          qb_w.delete(); qb_d.delete();
          return;
        end
        set_in(inst, 1'b1, mk_col(k, mode, b, x));
        if (start_mid && n == 1) set_start(inst, 1'b1);
        t = 0;
        while (!rd_ready(inst) && t < 50) begin
          @(posedge clk); #1;
          t++;
        end
        chk("ready_wait", rd_ready(inst), 1);
        @(posedge clk); #1;
        set_start(inst, 1'b0);
        n++;
        chk("vld_after_accept", rd_valid(inst), (x >= x0) ? 1 : 0);
        if (x == cols - 1 && b < rows - 1) begin
          set_in(inst, 1'b0, '0);
          lo = 0;
          while (!rd_ready(inst) && lo < 20) begin
            @(posedge clk); #1;
            lo++;
          end
          chk("ready_low_cycles", lo, PAD ? h : 0);
        end else if (gap && x < cols - 1) begin
          set_in(inst, 1'b0, '0);
          @(posedge clk); #1;
          chk("vld_in_gap", rd_valid(inst), 0);
        end
      end
    set_in(inst, 1'b0, '0);
    t = 0;
    while (rd_busy(inst) && t < 50) begin
      @(posedge clk); #1;
      t++;
    end
    chk("frame_end", rd_busy(inst), 0);
    repeat (2) @(posedge clk);
    #1;
    chk("queue_empty", (inst == 0) ? qa_w.size() : qb_w.size(), 0);
    chk("done_count", (inst == 0) ? done_a : done_b, 1);
  endtask

  // Monitors: pop one expected window per valid_o and compare window and done
  always @(negedge clk) begin
    logic [WB-1:0] ew;
    bit ed;
    if (ifa.valid_o) begin
      checks++;
      if (qa_w.size() == 0) begin
        errors++;
        $display("FAIL win_a_unexpected actual=%h required=none", ifa.window_o);
      end else begin
        ew = qa_w.pop_front();
        ed = qa_d.pop_front();
        if (ifa.window_o !== ew[WA-1:0]) begin
          errors++;
          $display("FAIL win_a actual=%h required=%h", ifa.window_o, ew[WA-1:0]);
        end
        chk("done_a", ifa.done_o, ed);
      end
      if (ifa.done_o) done_a++;
    end else begin
      chk("done_a_idle", ifa.done_o, 0);
    end
  end

  always @(negedge clk) begin
    logic [WB-1:0] ew;
    bit ed;
    if (ifb.valid_o) begin
      checks++;
      if (qb_w.size() == 0) begin
        errors++;
        $display("FAIL win_b_unexpected actual=%h required=none", ifb.window_o);
      end else begin
        ew = qb_w.pop_front();
        ed = qb_d.pop_front();
        if (ifb.window_o !== ew) begin
          errors++;
          $display("FAIL win_b actual=%h required=%h", ifb.window_o, ew);
        end
        chk("done_b", ifb.done_o, ed);
      end
      if (ifb.done_o) done_b++;
    end
  end

  initial begin
    #2000000;
    $display("FAIL watchdog actual=running required=finished");
    $fatal(1);
  end

  initial begin
    rst = 1'b1;
    ifa.start_i = 1'b0; ifa.valid_i = 1'b0; ifa.col_i = '0;
    ifb.start_i = 1'b0; ifb.valid_i = 1'b0; ifb.col_i = '0;
    repeat (3) @(posedge clk);
    #1;
    rst = 1'b0;
    chk_idle_outputs(0, "reset_a");
    chk_idle_outputs(1, "reset_b");

    run_frame(0, 0, 1'b0, 0, 1'b0);   // K=3 ramp, continuous
    run_frame(0, 1, 1'b0, 0, 1'b0);   // row boundary 0xFF / 0x00
    run_frame(1, 0, 1'b1, 0, 1'b0);   // K=7, 1-on/1-off gaps
    run_frame(1, 0, 1'b0, 0, 1'b0);   // K=7, continuous
    run_frame(0, 0, 1'b0, 3, 1'b0);   // reset after 3 columns
    run_frame(0, 0, 1'b0, 0, 1'b0);   // full frame after abort

    ifa.start_i = 1'b1;
    rst = 1'b1;
    @(posedge clk); #1;
    ifa.start_i = 1'b0;
    rst = 1'b0;
    chk("rst_start_busy", ifa.busy_o, 0);
    chk("rst_start_ready", ifa.ready_o, 0);
    @(posedge clk); #1;
    chk("rst_start_busy_later", ifa.busy_o, 0);

    run_frame(0, 0, 1'b1, 0, 1'b1);   // start_i during RUN, with gaps

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
